// File: rtl/ddfs_chirp_pkg.sv
// Shared types and constants for the chirp DDFS.
// Mode/state encodings, default widths and LFSR constants.
package ddfs_pkg;

    localparam int PW_DEF     = 30;
    localparam int LUT_AW_DEF = 10;
    localparam int DW_DEF     = 16;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_REPEAT   = 2'd1,
        MODE_PINGPONG = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ddfs_chirp_if.sv
// Control and sample-stream bundle of the chirp DDFS.
// master drives sweep control, slave is the synthesiser.
interface ddfs_chirp_if #(
    parameter int PW = 30,
    parameter int DW = 16
);
    logic                 tick;
    logic                 start;
    logic                 abort;
    logic [1:0]           mode;
    logic [PW-1:0]        f_start;
    logic [PW-1:0]        f_stop;
    logic [PW-1:0]        f_step;
    logic signed [DW-1:0] env;
    logic signed [DW-1:0] pcm_out;
    logic                 pcm_valid;
    logic [PW-1:0]        fccw_cur;
    logic                 busy;
    logic                 done;

    modport master (
        output tick, start, abort, mode,
        output f_start, f_stop, f_step, env,
        input  pcm_out, pcm_valid, fccw_cur, busy, done
    );

    modport slave (
        input  tick, start, abort, mode,
        input  f_start, f_stop, f_step, env,
        output pcm_out, pcm_valid, fccw_cur, busy, done
    );
endinterface

// File: rtl/ddfs_chirp_sin_lut.sv
// Registered full-wave sine ROM, contents built at elaboration.
// Entry k = round(A * sin(2*pi*k/2^LUT_AW)), A = 2^(DW-1)-1.
module ddfs_sin_lut #(
    parameter int LUT_AW = 10,
    parameter int DW     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en_i,
    input  logic [LUT_AW-1:0]    addr_i,
    output logic signed [DW-1:0] data_o
);
    localparam int  N   = 2 ** LUT_AW;
    localparam real AMP = $itor((2 ** (DW - 1)) - 1);
    localparam real PI2 = 6.283185307179586;

    logic signed [DW-1:0] rom [N];
    logic signed [DW-1:0] data_q;

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam real S = AMP * $sin(PI2 * k / N);
        localparam int  V = (S >= 0.0) ? $rtoi(S + 0.5)
                                       : $rtoi(S - 0.5);
        assign rom[k] = DW'(V);
    end

    // ROM read register, only advances for a live sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= rom[addr_i];
        end
    end

    assign data_o = data_q;
endmodule

// File: rtl/ddfs_chirp.sv
// Chirp DDFS: phase accumulator, linear sweep FSM, sine LUT, envelope.
// Optional phase dither when DDFS_CHIRP_DITHER_EN is defined.
module ddfs_chirp
    import ddfs_pkg::*;
#(
    parameter int PW     = PW_DEF,
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int DW     = DW_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    ddfs_chirp_if.slave bus
);
    localparam int PMAXI = (2 ** (DW - 1)) - 1;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] fccw_q, fccw_d;
    logic [PW-1:0] fstart_q, fstart_d;
    logic [PW-1:0] fstop_q, fstop_d;
    logic [PW-1:0] fstep_q, fstep_d;
    logic [1:0]    mode_q, mode_d;
    logic          done_q, done_d;

    logic          busy;
    logic          accept;
    logic          degen;
    logic [PW:0]   up_sum;
    logic [PW:0]   dn_floor;
    logic [PW-1:0] up_next;
    logic [PW-1:0] dn_next;

    assign busy   = (state_q != ST_IDLE);
    assign accept = bus.tick & busy & ~bus.start & ~bus.abort;
    assign degen  = (fstep_q == '0) || (fstart_q >= fstop_q);

    // sums carry one extra bit so the clamp never sees a wrapped word
    assign up_sum   = {1'b0, fccw_q} + {1'b0, fstep_q};
    assign up_next  = (up_sum > {1'b0, fstop_q}) ? fstop_q
                                                 : up_sum[PW-1:0];
    assign dn_floor = {1'b0, fstart_q} + {1'b0, fstep_q};
    assign dn_next  = ({1'b0, fccw_q} >= dn_floor) ? (fccw_q - fstep_q)
                                                   : fstart_q;

    // sweep FSM next state: abort beats start beats tick
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        fccw_d   = fccw_q;
        fstart_d = fstart_q;
        fstop_d  = fstop_q;
        fstep_d  = fstep_q;
        mode_d   = mode_q;
        done_d   = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            fccw_d  = '0;
        end else if (bus.start) begin
            fstart_d = bus.f_start;
            fstop_d  = bus.f_stop;
            fstep_d  = bus.f_step;
            mode_d   = bus.mode;
            phase_d  = '0;
            fccw_d   = bus.f_start;
            state_d  = ST_UP;
        end else if (accept) begin
            phase_d = phase_q + fccw_q;
            if (!degen) begin
                unique case (state_q)
                    ST_UP: begin
                        if (fccw_q == fstop_q) begin
                            unique case (1'b1)
                                (mode_q == MODE_REPEAT): begin
                                    fccw_d = fstart_q;
                                end
                                (mode_q == MODE_PINGPONG): begin
                                    state_d = ST_DOWN;
                                    fccw_d  = dn_next;
                                end
                                default: begin
                                    state_d = ST_IDLE;
                                    fccw_d  = '0;
                                    done_d  = 1'b1;
                                end
                            endcase
                        end else begin
                            fccw_d = up_next;
                        end
                    end
                    ST_DOWN: begin
                        if (fccw_q == fstart_q) begin
                            state_d = ST_UP;
                            fccw_d  = up_next;
                        end else begin
                            fccw_d = dn_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // sweep FSM and parameter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            fccw_q   <= '0;
            fstart_q <= '0;
            fstop_q  <= '0;
            fstep_q  <= '0;
            mode_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            fccw_q   <= fccw_d;
            fstart_q <= fstart_d;
            fstop_q  <= fstop_d;
            fstep_q  <= fstep_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    logic [PW-1:0] phase_src;

`ifdef DDFS_CHIRP_DITHER_EN
    logic [15:0]   lfsr_q;
    logic [PW-1:0] dith;

    // dither source steps once per produced sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (accept) begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign dith = PW'(lfsr_q)
                & ((PW'(1) << (PW - LUT_AW)) - PW'(1));
    assign phase_src = phase_q + dith;
`else
    assign phase_src = phase_q;
`endif

    logic [LUT_AW-1:0]      addr_q;
    logic                   v1_q, v2_q, v3_q;
    logic signed [DW-1:0]   lut_val;
    logic signed [DW-1:0]   pcm_q;
    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] shr;
    logic signed [DW-1:0]   sat;

    // stage 1: capture LUT address of the sample's phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= accept;
            if (accept) begin
                addr_q <= LUT_AW'(phase_src >> (PW - LUT_AW));
            end
        end
    end

    ddfs_sin_lut #(
        .LUT_AW (LUT_AW),
        .DW     (DW)
    ) u_lut (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (v1_q),
        .addr_i  (addr_q),
        .data_o  (lut_val)
    );

    // envelope scaling with symmetric saturation
    always_comb begin
        prod = $signed({{DW{lut_val[DW-1]}}, lut_val})
             * $signed({{DW{bus.env[DW-1]}}, bus.env});
        shr  = prod >>> (DW - 2);
        sat  = DW'(shr);
        if (shr > (2*DW)'(PMAXI)) begin
            sat = DW'(PMAXI);
        end else if (shr < (2*DW)'(-PMAXI)) begin
            sat = DW'(-PMAXI);
        end
    end

    // stages 2 and 3: LUT valid tracking and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            pcm_q <= '0;
        end else begin
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (v2_q) begin
                pcm_q <= sat;
            end
        end
    end

    assign bus.pcm_out   = pcm_q;
    assign bus.pcm_valid = v3_q;
    assign bus.fccw_cur  = fccw_q;
    assign bus.busy      = busy;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_ddfs_chirp.sv
// Scoreboard bench for ddfs_chirp: sweep words, done/busy, PCM values
// and three-clock sample latency against hand-computed vectors.
module tb_ddfs_chirp;
    import ddfs_pkg::*;

    localparam int PW     = 30;
    localparam int LUT_AW = 10;
    localparam int DW     = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ddfs_chirp_if #(.PW(PW), .DW(DW)) bus();

    ddfs_chirp #(
        .PW     (PW),
        .LUT_AW (LUT_AW),
        .DW     (DW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic signed [DW-1:0] v;
        int                   at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_pass = 0;
    int   n_tot  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        exp_t e;
        e.v  = DW'(v);
        e.at = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic go(input logic [1:0] m, input logic [PW-1:0] fs,
                      input logic [PW-1:0] fe, input logic [PW-1:0] st);
        bus.tick    = 1'b0;
        bus.mode    = m;
        bus.f_start = fs;
        bus.f_stop  = fe;
        bus.f_step  = st;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.tick = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // monitor: every presented sample must match the queue head
    always @(posedge clk) begin
        #1;
        if (bus.pcm_valid) begin
            if (sb.size() == 0) begin
                chk("pcm_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("pcm", bus.pcm_out, mon_e.v);
                chk("pcm_latency", cyc, mon_e.at);
            end
        end
    end

    int os_f[4]  = '{100, 110, 120, 130};
    int pp_f[11] = '{100, 112, 124, 130, 118, 106,
                     100, 112, 124, 130, 118};
    int rp_f[7]  = '{100, 110, 120, 100, 110, 120, 100};
    logic signed [DW-1:0] ev[4] = '{16'sh4000, 16'shC000,
                                    16'sh7FFF, 16'sh2000};
    int tv[4][4] = '{'{0, 32767, 0, -32767},
                     '{0, -32767, 0, 32767},
                     '{0, 32767, 0, -32767},
                     '{0, 16383, 0, -16384}};

    initial begin
        bus.tick    = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.mode    = 2'd0;
        bus.f_start = '0;
        bus.f_stop  = '0;
        bus.f_step  = '0;
        bus.env     = 16'sh4000;

        // reset held with activity on the inputs
        for (int i = 0; i < 6; i++) begin
            bus.tick  = i[0];
            bus.start = (i == 2);
            step();
        end
        bus.start = 1'b0;
        chk("rst_pcm", bus.pcm_out, 0);
        chk("rst_valid", bus.pcm_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fccw", bus.fccw_cur, 0);
        chk("rst_done", bus.done, 0);
        reset_n  = 1'b1;
        bus.tick = 1'b0;
        step();

        // one-shot 100/130/10
        go(MODE_ONESHOT, 100, 130, 10);
        for (int i = 0; i < 4; i++) begin
            chk("os_fccw", bus.fccw_cur, os_f[i]);
            chk("os_done_early", bus.done, 0);
            bus.tick = 1'b1;
            push(0);
            step();
        end
        bus.tick = 1'b0;
        chk("os_done", bus.done, 1);
        chk("os_busy", bus.busy, 0);
        chk("os_fccw_end", bus.fccw_cur, 0);
        chk("os_phase", dut.phase_q, 460);
        step();
        chk("os_done_pulse", bus.done, 0);
        drain(4);

        // ping-pong 100/130/12, then abort with samples in flight
        go(MODE_PINGPONG, 100, 130, 12);
        for (int i = 0; i < 11; i++) begin
            chk("pp_fccw", bus.fccw_cur, pp_f[i]);
            chk("pp_done", bus.done, 0);
            bus.tick = 1'b1;
            push(0);
            step();
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.tick  = 1'b0;
        chk("ab_busy", bus.busy, 0);
        chk("ab_fccw", bus.fccw_cur, 0);
        chk("ab_done", bus.done, 0);
        drain(5);

        // repeat 100/120/10, restart mid-sweep at 200
        go(MODE_REPEAT, 100, 120, 10);
        for (int i = 0; i < 7; i++) begin
            chk("rp_fccw", bus.fccw_cur, rp_f[i]);
            bus.tick = 1'b1;
            push(0);
            step();
        end
        bus.f_start = 200;
        bus.f_stop  = 300;
        bus.start   = 1'b1;
        step();
        bus.start = 1'b0;
        chk("rs_fccw", bus.fccw_cur, 200);
        chk("rs_phase", dut.phase_q, 0);
        push(0);
        step();
        chk("rs_fccw_next", bus.fccw_cur, 210);
        bus.tick  = 1'b0;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        drain(4);

        // start and abort together from IDLE
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", bus.busy, 0);
        chk("sa_fccw", bus.fccw_cur, 0);

        // quarter-wave tone under several envelopes
        go(MODE_ONESHOT, 30'h1000_0000, 30'h1000_0000, 1);
        for (int e = 0; e < 4; e++) begin
            bus.env = ev[e];
            for (int k = 0; k < 4; k++) begin
                bus.tick = 1'b1;
                push(tv[e][k]);
                step();
            end
            drain(4);
            chk("tone_fccw", bus.fccw_cur, 30'h1000_0000);
            chk("tone_busy", bus.busy, 1);
            chk("tone_done", bus.done, 0);
        end

        // restart while busy resets phase to 0
        bus.env  = 16'sh4000;
        bus.tick = 1'b1;
        push(0);
        step();
        bus.tick  = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.tick  = 1'b1;
        push(0);
        step();
        push(32767);
        step();
        drain(5);

        // reset mid-operation flushes the pipeline
        bus.tick = 1'b1;
        step();
        step();
        bus.tick = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("mr_valid_async", bus.pcm_valid, 0);
        step();
        reset_n = 1'b1;
        chk("mr_pcm", bus.pcm_out, 0);
        chk("mr_busy", bus.busy, 0);
        chk("mr_fccw", bus.fccw_cur, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("mr_valid", bus.pcm_valid, 0);
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) step();
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
